bnn_neuron_accumulator: RTL
===========================

// Module: bnn_neuron_accumulator
// PURPOSE
//  Neuron accumulate/threshold stage; consumes popcount results (XNOR-match counts) one beat per cycle.
//  Sums the beats of one input vector and compares the sum against a threshold.
//  Emits a binary activation bit plus the raw sum to the next layer over a valid/ready handshake.
// PARAMETERS
//  COUNTER_BITS  4   width of incoming popcount beat (in_count)
//  ACC_BITS      8   accumulator / threshold / out_sum width
//  MAX_BEATS     16  beats per vector; the MAX_BEATS-th accepted beat is treated as last
//  BEAT_BITS     5   beat-counter width; must hold MAX_BEATS
// PORTS
//  clk        in   1             clock, rising edge
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             in_count/in_last valid
//  in_ready   out  1             stage accepts a beat this cycle
//  in_count   in   COUNTER_BITS  popcount beat, unsigned
//  in_last    in   1             final beat of current vector
//  threshold  in   ACC_BITS      unsigned firing threshold, sampled on the final beat
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts result
//  out_bit    out  1             activation: 1 iff sum >= threshold
//  out_sum    out  ACC_BITS      accumulated sum of the vector
//  out_sat    out  1             sum saturated (ACC_SATURATE_EN only, else constant 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, acc=0, beat=0, out_valid=0, out_bit=0, out_sum=0, out_sat=0.
//  - States: IDLE (no partial sum), ACCUM (partial sum held), HOLD (result presented).
//  - in_ready = (state != HOLD), combinational; it is 1 during and straight after reset.
//  - Beat accepted when in_valid & in_ready. Otherwise all state is unchanged.
//  - On accept: sum_n = (IDLE ? 0 : acc) + zero-extended in_count; beat_n = (IDLE ? 0 : beat) + 1.
//  - Final beat = in_last | (beat_n == MAX_BEATS).
//  - Final beat accepted:
//      out_sum <= sum_n; out_bit <= (sum_n >= threshold); out_valid <= 1;
//      acc <= 0; beat <= 0; state -> HOLD.
//      Latency is 1 cycle: out_valid rises on the edge after the final beat.
//  - Non-final beat accepted: acc <= sum_n; beat <= beat_n; state -> ACCUM (IDLE->ACCUM, or stays ACCUM).
//  - HOLD: out_* stay stable and in_valid is ignored.
//      out_valid & out_ready -> out_valid <= 0, state -> IDLE on the next edge.
//      No same-cycle bypass, so at least one bubble per vector.
//  - out_valid never drops without out_ready.
//  - threshold is used only in the final-beat cycle; changing it later has no effect on out_bit.
//  - Single-beat vector (in_last on the first beat from IDLE): sum = in_count.
//  - Reset mid-vector or mid-HOLD: the partial sum and the pending result are discarded.
// CONFIGURATION
//  ACC_SATURATE_EN defined:
//      sum_n clamps at 2^ACC_BITS-1 once the true sum overflows.
//      Saturation is sticky for the rest of the vector.
//      out_sat <= 1 with the result; it clears on the next vector's result.
//  ACC_SATURATE_EN undefined:
//      sum_n wraps modulo 2^ACC_BITS; out_sat is constant 0.
//      The compare uses the wrapped value.
// TESTING
//  1 rst_n=0 mid-run -> out_valid=0, out_sum=0, out_bit=0, in_ready=1 immediately (async).
//  2 beats 5,8,3 (last on 3), threshold=16 -> next cycle: out_valid=1, out_sum=16, out_bit=1.
//  3 same beats, threshold=17 -> out_sum=16, out_bit=0.
//    Then a single beat 0 with last and threshold=0 -> out_bit=1.
//  4 result pending, out_ready=0 for 3 cycles, in_valid=1 -> out_* stable, in_ready=0, no beat consumed;
//    out_ready=1 -> out_valid=0 next cycle, in_ready=1.
//  5 ACC_BITS=6, five beats of 15, last on 5th -> no macro: out_sum=11, out_sat=0;
//    with ACC_SATURATE_EN: out_sum=63, out_sat=1.
//  6 MAX_BEATS=16, sixteen beats of 1, in_last=0 throughout -> out_valid after 16th beat, out_sum=16;
//    17th beat starts a new vector.

Source files
------------

// File: rtl/bnn_neuron_accumulator.sv
// Neuron accumulate/threshold stage: sums popcount beats of one vector and thresholds the sum.
// Optional macro ACC_SATURATE_EN clamps the running sum instead of wrapping and drives out_sat.
module bnn_neuron_accumulator #(
   parameter int COUNTER_BITS = 4,
   parameter int ACC_BITS     = 8,
   parameter int MAX_BEATS    = 16,
   parameter int BEAT_BITS    = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [COUNTER_BITS-1:0] in_count,
   input  logic                    in_last,
   input  logic [ACC_BITS-1:0]     threshold,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_bit,
   output logic [ACC_BITS-1:0]     out_sum,
   output logic                    out_sat
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]           state;
   logic [ACC_BITS-1:0]  acc;
   logic [ACC_BITS-1:0]  acc_base;
   logic [ACC_BITS-1:0]  sum_n;
   logic [BEAT_BITS-1:0] beat;
   logic [BEAT_BITS-1:0] beat_n;
   logic                 accept;
   logic                 final_beat;

   assign in_ready = (state != S_HOLD);
   assign accept   = in_valid & in_ready;

   // A beat from IDLE starts a fresh vector, so the stale accumulator is ignored.
   always_comb begin
      acc_base   = (state == S_IDLE) ? '0 : acc;
      beat_n     = ((state == S_IDLE) ? '0 : beat) + BEAT_BITS'(1);
      final_beat = in_last | (beat_n == BEAT_BITS'(MAX_BEATS));
   end

`ifdef ACC_SATURATE_EN
   logic                sat;
   logic                sat_n;
   logic [ACC_BITS:0]   sum_wide;

   // The sticky flag keeps the clamp alive even when later beats add zero.
   always_comb begin
      sum_wide = {1'b0, acc_base} + (ACC_BITS+1)'(in_count);
      sat_n    = ((state == S_ACCUM) & sat) | sum_wide[ACC_BITS];
      sum_n    = sat_n ? '1 : sum_wide[ACC_BITS-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat     <= 1'b0;
         out_sat <= 1'b0;
      end else if (accept) begin
         if (final_beat) begin
            sat     <= 1'b0;
            out_sat <= sat_n;
         end else begin
            sat     <= sat_n;
         end
      end
   end
`else
   always_comb begin
      sum_n = acc_base + ACC_BITS'(in_count);
   end

   assign out_sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         beat      <= '0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_sum   <= '0;
      end else if (state == S_HOLD) begin
         if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
         end
      end else if (accept) begin
         if (final_beat) begin
            out_sum   <= sum_n;
            out_bit   <= (sum_n >= threshold);
            out_valid <= 1'b1;
            acc       <= '0;
            beat      <= '0;
            state     <= S_HOLD;
         end else begin
            acc       <= sum_n;
            beat      <= beat_n;
            state     <= S_ACCUM;
         end
      end
   end

endmodule
